// File: rtl/acc_pkg.sv
// Shared constants and stack-operation encoding for the accumulator bank,
// its save stack, the control unit that drives them, and the testbench.
package acc_pkg;

    localparam int ACC_DATA_W      = 16;
    localparam int ACC_NUM         = 4;
    localparam int ACC_STACK_DEPTH = 8;

    // Encoding is {push, pop}, so a request pair casts straight onto it.
    typedef enum logic [1:0] {
        STK_NONE     = 2'b00,
        STK_POP      = 2'b01,
        STK_PUSH     = 2'b10,
        STK_CONFLICT = 2'b11
    } stk_op_e;

    function automatic stk_op_e acc_stk_op(input logic push, input logic pop);
        return stk_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/acc_stack.sv
// LIFO save stack: push/pop with full/empty status and a sticky error flag
// for push-when-full, pop-when-empty and simultaneous push+pop.
module acc_stack
    import acc_pkg::*;
#(
    parameter int DATA_W = ACC_DATA_W,
    parameter int DEPTH  = ACC_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_ok,
    output logic              full,
    output logic              empty,
    output logic              err
);

    localparam int SP_W = $clog2(DEPTH + 1);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_MAX = SP_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [SP_W-1:0]   sp_reg, sp_next, sp_dec;
    logic              err_reg, err_next;
    stk_op_e           op;

    assign op     = acc_stk_op(push, pop);
    assign sp_dec = sp_reg - 1'b1;
    assign full   = (sp_reg == SP_MAX);
    assign empty  = (sp_reg == '0);
    assign err    = err_reg;

    // The top entry is read combinationally so a pop lands in its register
    // at the same edge that moves the pointer.
    assign pop_data = mem[sp_dec[AW-1:0]];
    assign pop_ok   = (op == STK_POP) && !empty;

    always_comb begin
        sp_next  = sp_reg;
        err_next = err_reg;
        unique case (op)
            STK_CONFLICT: err_next = 1'b1;
            STK_PUSH: begin
                if (full) err_next = 1'b1;
                else      sp_next  = sp_reg + 1'b1;
            end
            STK_POP: begin
                if (empty) err_next = 1'b1;
                else       sp_next  = sp_dec;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sp_reg  <= '0;
            err_reg <= 1'b0;
        end else begin
            sp_reg  <= sp_next;
            err_reg <= err_next;
        end
    end

    // Entry contents are not reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (!rst && !clr && op == STK_PUSH && !full)
            mem[sp_reg[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/acc_bank.sv
// Bank of accumulators fed from the ALU result bus, with one combinational
// read port, zero/negative flags and a save stack for subroutine calls.
module acc_bank
    import acc_pkg::*;
#(
    parameter int DATA_W      = ACC_DATA_W,
    parameter int NUM_ACC     = ACC_NUM,
    parameter int STACK_DEPTH = ACC_STACK_DEPTH,
    localparam int SEL_W      = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_clr,
    input  logic              acc_alu_io_rw,
    input  logic [SEL_W-1:0]  acc_wr_sel,
    input  logic [DATA_W-1:0] alu2acc,
    input  logic [SEL_W-1:0]  acc_rd_sel,
    output logic [DATA_W-1:0] acc_data,
    output logic              acc_zero,
    output logic              acc_neg,
    input  logic              acc_push,
    input  logic              acc_pop,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              stk_err
);

    localparam logic [SEL_W:0] NUM_ACC_L = (SEL_W + 1)'(NUM_ACC);

    logic [DATA_W-1:0] acc_reg [NUM_ACC];
    logic              wr_valid, rd_valid;
    logic [DATA_W-1:0] push_data, pop_data;
    logic              pop_ok;

    assign wr_valid = ({1'b0, acc_wr_sel} < NUM_ACC_L);
    assign rd_valid = ({1'b0, acc_rd_sel} < NUM_ACC_L);

    // An out-of-range select silently drops push/pop so it never flags an error.
    assign push_data = wr_valid ? acc_reg[acc_wr_sel] : '0;

    acc_stack #(
        .DATA_W (DATA_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .clr       (acc_clr),
        .push      (acc_push && wr_valid),
        .pop       (acc_pop && wr_valid),
        .push_data (push_data),
        .pop_data  (pop_data),
        .pop_ok    (pop_ok),
        .full      (stk_full),
        .empty     (stk_empty),
        .err       (stk_err)
    );

    for (genvar gi = 0; gi < NUM_ACC; gi++) begin : g_acc
        logic wr_hit;
        assign wr_hit = wr_valid && (acc_wr_sel == SEL_W'(gi));

        // A successful pop wins over an ALU write to the same register.
        always_ff @(posedge clk) begin
            if (rst || acc_clr)
                acc_reg[gi] <= '0;
            else if (wr_hit && pop_ok)
                acc_reg[gi] <= pop_data;
            else if (wr_hit && acc_alu_io_rw)
                acc_reg[gi] <= alu2acc;
        end
    end

    assign acc_data = rd_valid ? acc_reg[acc_rd_sel] : '0;
    assign acc_zero = (acc_data == '0);
    assign acc_neg  = acc_data[DATA_W-1];

endmodule

// File: tb/tb_acc_bank.sv
// Directed plus random stimulus for acc_bank, checked against a queue-based
// reference model of the registers and save stack.
module tb_acc_bank;
    import acc_pkg::*;

    localparam int DW = 16;
    localparam int NA = 4;
    localparam int SD = 8;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst, acc_clr, acc_alu_io_rw, acc_push, acc_pop;
    logic [SW-1:0] acc_wr_sel, acc_rd_sel;
    logic [DW-1:0] alu2acc, acc_data;
    logic          acc_zero, acc_neg, stk_full, stk_empty, stk_err;

    always #5 clk = ~clk;

    acc_bank #(.DATA_W(DW), .NUM_ACC(NA), .STACK_DEPTH(SD)) dut (
        .clk(clk), .rst(rst), .acc_clr(acc_clr), .acc_alu_io_rw(acc_alu_io_rw),
        .acc_wr_sel(acc_wr_sel), .alu2acc(alu2acc), .acc_rd_sel(acc_rd_sel),
        .acc_data(acc_data), .acc_zero(acc_zero), .acc_neg(acc_neg),
        .acc_push(acc_push), .acc_pop(acc_pop), .stk_full(stk_full),
        .stk_empty(stk_empty), .stk_err(stk_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    logic [DW-1:0] m_reg [NA];
    logic [DW-1:0] m_stk [$];
    bit            m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NA; i++) begin
            acc_rd_sel = SW'(i);
            #1;
            chk($sformatf("acc_data[%0d]", i), 32'(acc_data), 32'(m_reg[i]));
            chk($sformatf("acc_zero[%0d]", i), 32'(acc_zero), 32'(m_reg[i] == '0));
            chk($sformatf("acc_neg[%0d]", i), 32'(acc_neg), 32'(m_reg[i][DW-1]));
        end
        chk("stk_full", 32'(stk_full), 32'(m_stk.size() == SD));
        chk("stk_empty", 32'(stk_empty), 32'(m_stk.size() == 0));
        chk("stk_err", 32'(stk_err), 32'(m_err));
    endtask

    // Reference behaviour: clear beats everything; push+pop is an error with
    // no stack change; a successful pop replaces the write; push saves the
    // pre-edge register value.
    task automatic model(input bit r, input bit c, input bit wr, input int sel,
                         input logic [DW-1:0] d, input bit pu, input bit po);
        bit            popped;
        logic [DW-1:0] old;
        popped = 0;
        if (r || c) begin
            for (int i = 0; i < NA; i++) m_reg[i] = '0;
            m_stk.delete();
            m_err = 0;
        end else begin
            old = m_reg[sel];
            if (pu && po) m_err = 1;
            else if (po) begin
                if (m_stk.size() == 0) m_err = 1;
                else begin
                    m_reg[sel] = m_stk.pop_back();
                    popped = 1;
                end
            end else if (pu) begin
                if (m_stk.size() == SD) m_err = 1;
                else m_stk.push_back(old);
            end
            if (wr && !popped) m_reg[sel] = d;
        end
    endtask

    task automatic step(input bit r, input bit c, input bit wr, input int sel,
                        input logic [DW-1:0] d, input bit pu, input bit po);
        rst = r; acc_clr = c; acc_alu_io_rw = wr; acc_wr_sel = SW'(sel);
        alu2acc = d; acc_push = pu; acc_pop = po; acc_rd_sel = SW'(sel);
        #1;
        if (!r) chk("read_old", 32'(acc_data), 32'(m_reg[sel]));
        @(posedge clk);
        model(r, c, wr, sel, d, pu, po);
        #1;
        rst = 0; acc_clr = 0; acc_alu_io_rw = 0; acc_push = 0; acc_pop = 0;
        $display("txn %0d rst=%0b clr=%0b wr=%0b sel=%0d data=%04h op=%s depth=%0d err=%0b",
                 n_txn, r, c, wr, sel, d, acc_stk_op(pu, po).name(), m_stk.size(), m_err);
        n_txn++;
        check_all();
    endtask

    initial begin
        rst = 1; acc_clr = 0; acc_alu_io_rw = 0; acc_push = 0; acc_pop = 0;
        acc_wr_sel = '0; acc_rd_sel = '0; alu2acc = '0;
        for (int i = 0; i < NA; i++) m_reg[i] = '0;
        m_err = 0;

        step(1, 0, 0, 0, 16'h0, 0, 0);
        step(1, 0, 0, 0, 16'h0, 0, 0);
        step(0, 0, 0, 0, 16'h0, 0, 0);

        step(0, 0, 1, 2, 16'h8001, 0, 0);
        step(0, 0, 1, 2, 16'h1234, 1, 0);
        step(0, 0, 0, 3, 16'h0, 0, 1);

        for (int k = 1; k <= SD; k++) begin
            step(0, 0, 1, 0, DW'(k), 0, 0);
            step(0, 0, 0, 0, 16'h0, 1, 0);
        end
        step(0, 0, 0, 1, 16'h0, 1, 0);
        for (int k = 0; k < SD; k++) step(0, 0, 0, 0, 16'h0, 0, 1);

        step(0, 1, 0, 0, 16'h0, 0, 0);
        step(0, 0, 1, 1, 16'h00FF, 0, 1);
        step(0, 1, 0, 0, 16'h0, 0, 0);
        step(0, 0, 0, 1, 16'h0, 1, 0);
        step(0, 0, 1, 2, 16'h5A5A, 1, 1);

        for (int k = 0; k < 3; k++) step(0, 0, 1, k, DW'(16'hC000 + k), 1, 0);
        step(0, 0, 0, 0, 16'h0, 0, 1);
        step(0, 0, 0, 0, 16'h0, 0, 1);
        step(0, 0, 0, 0, 16'h0, 0, 1);
        step(0, 0, 0, 0, 16'h0, 0, 1);
        step(0, 1, 1, 3, 16'hBEEF, 1, 0);

        for (int k = 0; k < 400; k++) begin
            bit pu, po, wr, c;
            wr = 1'($urandom_range(0, 1));
            pu = ($urandom_range(0, 99) < ((k % 100) < 50 ? 45 : 15));
            po = ($urandom_range(0, 99) < ((k % 100) < 50 ? 15 : 45));
            c  = ($urandom_range(0, 63) == 0);
            step(0, c, wr, $urandom_range(0, NA - 1), DW'($urandom), pu, po);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
